// File: rtl/tc_octet_scheduler.sv
// tc_octet_scheduler: dispatches tiles to octets, round-robin arbitrates the shared fetch port, counts finished tiles.
// Optional fetch watchdog enabled by SCHED_FETCH_TIMEOUT_EN.
module tc_octet_scheduler #(
   parameter int NUM_OCTETS = 4,
   parameter int ID_WIDTH = 2,
   parameter int FETCH_BEATS = 4,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tile_valid,
   output logic                  tile_ready,
   input  logic [NUM_OCTETS-1:0] octet_idle,
   input  logic [NUM_OCTETS-1:0] octet_fetch,
   input  logic [NUM_OCTETS-1:0] octet_write_back,
   output logic [NUM_OCTETS-1:0] octet_start,
   output logic [NUM_OCTETS-1:0] octet_fetch_done,
   output logic                  mem_req,
   output logic [ID_WIDTH-1:0]   mem_gnt_id,
   input  logic                  mem_ack,
   output logic [15:0]           tiles_done,
   output logic                  busy,
   output logic                  fetch_err
);
   localparam int CW = FETCH_BEATS > 1 ? $clog2(FETCH_BEATS) : 1;
   localparam logic [NUM_OCTETS-1:0] ONE = 1;
   typedef enum logic [1:0] {
      ARB_IDLE,
`ifdef SCHED_FETCH_TIMEOUT_EN
      ARB_HALT,
`endif
      ARB_XFER
   } arb_t;
   arb_t state;
   logic [NUM_OCTETS-1:0] alloc, served, wb_q, free, fall, disp, elig, done_mask;
   logic [ID_WIDTH-1:0] rr, pick;
   logic [CW-1:0] cnt;
   logic [15:0] inc;
   logic accept;
   assign free = ~alloc & octet_idle;
   assign tile_ready = rst & |free;
   assign accept = tile_valid & tile_ready;
   assign fall = wb_q & ~octet_write_back;
   assign elig = octet_fetch & ~served;
   assign done_mask = ONE << mem_gnt_id;
   assign mem_req = state == ARB_XFER;
   assign busy = |alloc | (state != ARB_IDLE);
   // reverse loops let the lowest index / nearest-after-rr candidate win
   always_comb begin
      disp = '0;
      pick = '0;
      inc = '0;
      for (int i = NUM_OCTETS - 1; i >= 0; i--)
         if (free[i]) disp = ONE << i;
      for (int k = NUM_OCTETS; k >= 1; k--)
         if (elig[(int'(rr) + k) % NUM_OCTETS]) pick = ID_WIDTH'((int'(rr) + k) % NUM_OCTETS);
      for (int i = 0; i < NUM_OCTETS; i++)
         inc = inc + 16'(fall[i]);
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         alloc <= '0;
         wb_q <= '0;
         octet_start <= '0;
         tiles_done <= '0;
      end else begin
         wb_q <= octet_write_back;
         tiles_done <= tiles_done + inc;
         octet_start <= accept ? disp : '0;
         alloc <= (alloc & ~fall) | (accept ? disp : '0);
      end
   end
`ifdef SCHED_FETCH_TIMEOUT_EN
   localparam int SW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [SW-1:0] stall;
`else
   assign fetch_err = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= ARB_IDLE;
         rr <= ID_WIDTH'(NUM_OCTETS - 1);
         mem_gnt_id <= '0;
         cnt <= '0;
         served <= '0;
         octet_fetch_done <= '0;
`ifdef SCHED_FETCH_TIMEOUT_EN
         stall <= '0;
         fetch_err <= 1'b0;
`endif
      end else begin
         octet_fetch_done <= '0;
         served <= served & octet_fetch;
         case (state)
            ARB_IDLE: if (|elig) begin
               mem_gnt_id <= pick;
               rr <= pick;
               state <= ARB_XFER;
`ifdef SCHED_FETCH_TIMEOUT_EN
               stall <= '0;
`endif
            end
            ARB_XFER: if (mem_ack) begin
`ifdef SCHED_FETCH_TIMEOUT_EN
               stall <= '0;
`endif
               if (cnt == CW'(FETCH_BEATS - 1)) begin
                  cnt <= '0;
                  octet_fetch_done <= done_mask;
                  served <= (served | done_mask) & octet_fetch;
                  state <= ARB_IDLE;
               end else cnt <= cnt + CW'(1);
            end
`ifdef SCHED_FETCH_TIMEOUT_EN
            else if (stall == SW'(TIMEOUT_CYCLES - 1)) begin
               fetch_err <= 1'b1;
               state <= ARB_HALT;
            end else stall <= stall + SW'(1);
`endif
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_tc_octet_scheduler.sv
// tb_tc_octet_scheduler: per-cycle vector table plus hand sequences for counter wrap and fetch stall.
module tb_tc_octet_scheduler;
   logic clk = 0, rst = 0, tile_valid = 0, mem_ack = 0;
   logic [3:0] octet_idle = 4'hF, octet_fetch = 0, octet_write_back = 0;
   logic tile_ready, mem_req, busy, fetch_err;
   logic [3:0] octet_start, octet_fetch_done;
   logic [1:0] mem_gnt_id;
   logic [15:0] tiles_done;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   tc_octet_scheduler #(.NUM_OCTETS(4), .ID_WIDTH(2), .FETCH_BEATS(4), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst(rst), .tile_valid(tile_valid), .tile_ready(tile_ready),
      .octet_idle(octet_idle), .octet_fetch(octet_fetch), .octet_write_back(octet_write_back),
      .octet_start(octet_start), .octet_fetch_done(octet_fetch_done), .mem_req(mem_req),
      .mem_gnt_id(mem_gnt_id), .mem_ack(mem_ack), .tiles_done(tiles_done), .busy(busy),
      .fetch_err(fetch_err)
   );
   typedef struct {
      logic rst, tv;
      logic [3:0] idle, fetch, wb;
      logic ack, rdy;
      logic [3:0] st, dn;
      logic req;
      logic [1:0] gid;
      logic [15:0] tiles;
      logic busy;
   } vec_t;
   vec_t tbl[$];
   function automatic vec_t v(input logic r, tv, input logic [3:0] i, f, w, input logic a, rdy,
                              input logic [3:0] st, dn, input logic req, input logic [1:0] g,
                              input logic [15:0] t, input logic b);
      vec_t x;
      x.rst = r; x.tv = tv; x.idle = i; x.fetch = f; x.wb = w; x.ack = a;
      x.rdy = rdy; x.st = st; x.dn = dn; x.req = req; x.gid = g; x.tiles = t; x.busy = b;
      return x;
   endfunction
   task automatic chk(input string name, input logic [31:0] got, exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   initial begin
      // fields: rst tv idle fetch wb ack | rdy start done req gid tiles busy
      tbl.push_back(v(0,0,4'hF,4'h0,4'h0,0, 0,4'h0,4'h0,0,0,0,0));
      tbl.push_back(v(1,1,4'hF,4'h0,4'h0,0, 1,4'h0,4'h0,0,0,0,0));
      tbl.push_back(v(1,0,4'hF,4'h1,4'h0,0, 1,4'h1,4'h0,0,0,0,1));
      repeat (4) tbl.push_back(v(1,0,4'hF,4'h1,4'h0,1, 1,4'h0,4'h0,1,0,0,1));
      tbl.push_back(v(1,0,4'hF,4'h1,4'h0,0, 1,4'h0,4'h1,0,0,0,1));
      tbl.push_back(v(1,0,4'hF,4'h0,4'h1,0, 1,4'h0,4'h0,0,0,0,1));
      tbl.push_back(v(1,0,4'hF,4'h0,4'h0,0, 1,4'h0,4'h0,0,0,0,1));
      tbl.push_back(v(1,0,4'hF,4'h0,4'h0,0, 1,4'h0,4'h0,0,0,1,0));
      tbl.push_back(v(0,0,4'hF,4'h0,4'h0,0, 0,4'h0,4'h0,0,0,1,0));
      tbl.push_back(v(1,0,4'hF,4'hD,4'h0,0, 1,4'h0,4'h0,0,0,0,0));
      repeat (4) tbl.push_back(v(1,0,4'hF,4'hD,4'h0,1, 1,4'h0,4'h0,1,0,0,1));
      tbl.push_back(v(1,0,4'hF,4'hD,4'h0,0, 1,4'h0,4'h1,0,0,0,0));
      tbl.push_back(v(1,0,4'hF,4'hC,4'h0,1, 1,4'h0,4'h0,1,2,0,1));
      repeat (3) tbl.push_back(v(1,0,4'hF,4'hD,4'h0,1, 1,4'h0,4'h0,1,2,0,1));
      tbl.push_back(v(1,0,4'hF,4'hD,4'h0,0, 1,4'h0,4'h4,0,2,0,0));
      for (int k = 0; k < 7; k++) tbl.push_back(v(1,0,4'hF,4'hD,4'h0,~k[0], 1,4'h0,4'h0,1,3,0,1));
      tbl.push_back(v(1,0,4'hF,4'hD,4'h0,0, 1,4'h0,4'h8,0,3,0,0));
      repeat (2) tbl.push_back(v(1,0,4'hF,4'hD,4'h0,1, 1,4'h0,4'h0,1,0,0,1));
      tbl.push_back(v(0,0,4'hF,4'hD,4'h0,1, 0,4'h0,4'h0,1,0,0,1));
      tbl.push_back(v(1,0,4'hF,4'h6,4'h0,0, 1,4'h0,4'h0,0,0,0,0));
      repeat (4) tbl.push_back(v(1,0,4'hF,4'h0,4'h0,1, 1,4'h0,4'h0,1,1,0,1));
      tbl.push_back(v(1,0,4'hF,4'h0,4'h0,0, 1,4'h0,4'h2,0,1,0,0));
      tbl.push_back(v(1,1,4'h0,4'h0,4'h0,1, 0,4'h0,4'h0,0,1,0,0));
      tbl.push_back(v(1,1,4'hF,4'h0,4'h0,0, 1,4'h0,4'h0,0,1,0,0));
      tbl.push_back(v(1,1,4'hF,4'h0,4'h0,0, 1,4'h1,4'h0,0,1,0,1));
      tbl.push_back(v(1,1,4'hF,4'h0,4'h0,0, 1,4'h2,4'h0,0,1,0,1));
      tbl.push_back(v(1,1,4'hF,4'h0,4'h0,0, 1,4'h4,4'h0,0,1,0,1));
      tbl.push_back(v(1,1,4'hF,4'h0,4'h0,0, 0,4'h8,4'h0,0,1,0,1));
      tbl.push_back(v(1,1,4'hF,4'h0,4'h2,0, 0,4'h0,4'h0,0,1,0,1));
      tbl.push_back(v(1,1,4'hF,4'h0,4'h0,0, 0,4'h0,4'h0,0,1,0,1));
      tbl.push_back(v(1,1,4'hF,4'h0,4'h0,0, 1,4'h0,4'h0,0,1,1,1));
      tbl.push_back(v(1,0,4'hF,4'h0,4'h0,0, 0,4'h2,4'h0,0,1,1,1));
      tbl.push_back(v(1,0,4'hF,4'h0,4'hD,0, 0,4'h0,4'h0,0,1,1,1));
      tbl.push_back(v(1,0,4'hF,4'h0,4'h0,0, 0,4'h0,4'h0,0,1,1,1));
      tbl.push_back(v(1,0,4'hF,4'h0,4'h0,0, 1,4'h0,4'h0,0,1,4,1));
      repeat (2) @(posedge clk);
      foreach (tbl[n]) begin
         @(negedge clk);
         rst = tbl[n].rst; tile_valid = tbl[n].tv; octet_idle = tbl[n].idle;
         octet_fetch = tbl[n].fetch; octet_write_back = tbl[n].wb; mem_ack = tbl[n].ack;
         #1;
         chk($sformatf("row%0d {rdy,start,done,req,gid,tiles,busy,err}", n),
             {2'b0, tile_ready, octet_start, octet_fetch_done, mem_req, mem_gnt_id, tiles_done, busy, fetch_err},
             {2'b0, tbl[n].rdy, tbl[n].st, tbl[n].dn, tbl[n].req, tbl[n].gid, tbl[n].tiles, tbl[n].busy, 1'b0});
      end
      for (int k = 0; k < 16382; k++) begin
         octet_write_back = 4'hF; tick;
         octet_write_back = 4'h0; tick;
      end
      repeat (3) begin
         octet_write_back = 4'h1; tick;
         octet_write_back = 4'h0; tick;
      end
      chk("tiles_full", 32'(tiles_done), 32'hFFFF);
      octet_write_back = 4'h1; tick;
      octet_write_back = 4'h0; tick;
      chk("tiles_wrap", 32'(tiles_done), 32'h0);
      rst = 0; tick;
      rst = 1; octet_fetch = 4'h1; tick;
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("stall_req%0d", k), 32'(mem_req), 32'h1);
         tick;
      end
`ifdef SCHED_FETCH_TIMEOUT_EN
      chk("timeout_req", 32'(mem_req), 32'h0);
      chk("timeout_err", 32'(fetch_err), 32'h1);
      octet_fetch = 4'h0; tick;
      octet_fetch = 4'h2; tick; tick;
      chk("halt_no_grant", 32'(mem_req), 32'h0);
`else
      repeat (4) tick;
      chk("wait_req", 32'(mem_req), 32'h1);
      chk("wait_err", 32'(fetch_err), 32'h0);
`endif
      octet_fetch = 4'h0; tile_valid = 1; tick;
      tile_valid = 0;
      chk("stall_dispatch", 32'(octet_start), 32'h1);
      tick;
      chk("stall_start_end", 32'(octet_start), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/tc_octet_scheduler.md
Name: tc_octet_scheduler

Overview:
- Tensor-core level scheduler for a group of sparse octet units.
- Dispatches incoming tile jobs to free octets by pulsing their start inputs.
- Round-robin arbitrates the single shared operand-fetch port among octets that request fetch, and returns fetch_done to the served octet.
- Counts completed tiles by watching each octet's write_back phase.

Parameters:
NUM_OCTETS, 4, number of octet units scheduled.
ID_WIDTH, 2, width of octet index (log2 NUM_OCTETS, min 1).
FETCH_BEATS, 4, acknowledged memory beats per fetch transaction (>=1).
TIMEOUT_CYCLES, 256, watchdog limit; used only with the optional feature.

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  reset; one clock; reset is synchronous and active-low.
tile_valid  in  1  new tile job offered.
tile_ready  out  1  scheduler can accept a tile this cycle.
octet_idle  in  NUM_OCTETS  per-octet idle status.
octet_fetch  in  NUM_OCTETS  per-octet fetch phase (fetch request).
octet_write_back  in  NUM_OCTETS  per-octet write_back phase.
octet_start  out  NUM_OCTETS  one-cycle start pulse per octet.
octet_fetch_done  out  NUM_OCTETS  one-cycle fetch-complete pulse per octet.
mem_req  out  1  shared fetch port request.
mem_gnt_id  out  ID_WIDTH  octet owning the fetch port.
mem_ack  in  1  one beat accepted/delivered this cycle.
tiles_done  out  16  completed-tile counter.
busy  out  1  any octet allocated or arbiter not idle.
fetch_err  out  1  sticky watchdog error (optional feature).

Behaviour:
- Reset (rst=0 at clk edge): all outputs 0; alloc, served and beat count cleared; arbiter ARB_IDLE; rr pointer = NUM_OCTETS-1, so octet 0 has first priority. Reset mid-transfer aborts the transfer without fetch_done.
- Allocation: alloc[i] set on dispatch to i, cleared on the cycle after octet_write_back[i] falls 1->0.
- tile_ready is combinational: 1 when rst=1 and any octet has alloc=0 and octet_idle=1.
- Dispatch: tile_valid & tile_ready accepts the tile to the lowest-index eligible octet i. alloc[i] is set at that edge, and octet_start[i] pulses for exactly the next cycle. At most one dispatch per cycle.
- Arbiter FSM, ARB_IDLE:
  - Eligible octets: octet_fetch[i]=1 & served[i]=0.
  - Pick the first eligible index after rr, wrapping modulo NUM_OCTETS.
  - Register mem_gnt_id, set rr to the pick, then go to ARB_XFER.
- Arbiter FSM, ARB_XFER:
  - mem_req=1 and mem_gnt_id held stable.
  - Beat counter increments on mem_ack.
  - On mem_ack with count = FETCH_BEATS-1: pulse octet_fetch_done[id] next cycle, set served[id], clear the counter, return to ARB_IDLE.
  - Grant-to-grant gap is at least one cycle.
- Outside ARB_XFER, mem_req=0 and mem_gnt_id holds its last value. mem_ack outside XFER is ignored.
- served[i] clears when octet_fetch[i]=0, so an octet is served once per fetch phase. If octet_fetch[id] drops mid-transfer, the transfer still completes and fetch_done still pulses.
- tiles_done increments by the popcount of write_back falling edges in the cycle (simultaneous finishes all counted). It wraps at 2^16 (0xFFFF -> 0).
- Dispatch and arbitration are independent and may occur in the same cycle. A just-dispatched octet is arbitrated normally once it raises fetch.
- busy = |alloc | (state != ARB_IDLE).

Optional Feature:
Macro SCHED_FETCH_TIMEOUT_EN.
- Defined:
  - In ARB_XFER, a stall counter resets on every mem_ack and increments otherwise.
  - Reaching TIMEOUT_CYCLES with no ack: fetch_err set sticky, mem_req drops next cycle, FSM enters ARB_HALT.
  - ARB_HALT: no grants and no fetch_done; dispatch continues. Exit only by reset.
- Undefined: no stall counter, no ARB_HALT state, fetch_err tied 0, XFER waits indefinitely.

Test Plan:
- Single tile: tile_valid=1 with all octets idle -> tile_ready=1, octet_start=4'b0001 for one cycle. Octet 0 raises fetch, 4 acks -> fetch_done[0] pulses on the cycle after the 4th ack. write_back 1->0 -> tiles_done=1.
- Contention: octets 0,2,3 fetch simultaneously with rr=NUM_OCTETS-1 -> grant order 0,2,3; each takes 4 acks, with mem_gnt_id stable during each transfer. Re-request by octet 0 after 2 -> grant order resumes at 3, then 0.
- Saturation: all 4 octets allocated -> tile_ready=0 and tile_valid is ignored. Octet 1 finishes -> tile_ready=1, and the next tile starts octet 1.
- Ack gaps: acks on alternate cycles -> fetch_done occurs only after the 4th ack. No fetch_done for an octet whose fetch stays high after being served.
- Reset: rst=0 mid-XFER after 2 acks -> next cycle mem_req=0, busy=0, tiles_done=0, no fetch_done. Next grant goes to the lowest requesting index.
- SCHED_FETCH_TIMEOUT_EN with TIMEOUT_CYCLES=8: no ack for 8 cycles -> fetch_err=1 and mem_req=0. Later requests are not granted, and tile dispatch still works.
